pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter with a valid/ready handshake on input and output.
- Modes: logical, arithmetic and rotate shifts in both directions on a WIDTH-bit operand.
- Each power-of-two shift step sits in its own registered stage, so one operation is accepted per cycle. A sideband tag travels with the data.
- Feeds the ALU shift path and any multi-cycle datapath that needs a registered shift.

---
 rtl/shifter_pkg.sv | 10 +
 rtl/shifter_stage.sv | 76 +++++++
 rtl/pipelined_barrel_shifter.sv | 89 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared mode and direction encodings for the pipelined barrel shifter.
package shifter_pkg;
  localparam logic [1:0] MODE_LOGICAL = 2'b00;
  localparam logic [1:0] MODE_ARITH   = 2'b01;
  localparam logic [1:0] MODE_ROTATE  = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shifter_stage.sv
// One registered barrel-shifter step: conditionally shifts by STEP and holds
// the operation fields until the downstream stage can take them.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prev_vld,
  input  logic [WIDTH-1:0]           prev_data,
  input  logic [$clog2(WIDTH)-1:0]   prev_shift,
  input  logic                       prev_dir,
  input  logic [1:0]                 prev_mode,
  input  logic                       prev_sign,
  input  logic [TAG_W-1:0]           prev_tag,
  input  logic                       next_ready,
  output logic                       ready,
  output logic                       vld_p0,
  output logic [WIDTH-1:0]           data_p0,
  output logic [$clog2(WIDTH)-1:0]   shift_p0,
  output logic                       dir_p0,
  output logic [1:0]                 mode_p0,
  output logic                       sign_p0,
  output logic [TAG_W-1:0]           tag_p0
);
  localparam int BIT = $clog2(STEP);

  function automatic logic [WIDTH-1:0] step_shift(
    input logic [WIDTH-1:0] d,
    input logic             dir,
    input logic [1:0]       mode,
    input logic             sign
  );
    logic [WIDTH-1:0] lsl, lsr, asr, rot;
    logic [WIDTH-1:0] r;
    lsl = {d[WIDTH-STEP-1:0], {STEP{1'b0}}};
    lsr = {{STEP{1'b0}}, d[WIDTH-1:STEP]};
    // Vacated MSBs come from the original operand's sign, not the current MSB.
    asr = {{STEP{sign}}, d[WIDTH-1:STEP]};
    rot = (dir == DIR_LEFT) ? {d[WIDTH-STEP-1:0], d[WIDTH-1:WIDTH-STEP]}
                            : {d[STEP-1:0], d[WIDTH-1:STEP]};
    r = d;
    case (mode)
      MODE_ROTATE:             r = rot;
      MODE_ARITH:              r = (dir == DIR_LEFT) ? lsl : asr;
      MODE_LOGICAL, MODE_RSVD: r = (dir == DIR_LEFT) ? lsl : lsr;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] shifted;

  assign shifted = prev_shift[BIT] ? step_shift(prev_data, prev_dir, prev_mode, prev_sign)
                                   : prev_data;
  assign ready   = !vld_p0 || next_ready;

  // ---- stage register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      tag_p0  <= '0;
    end else if (ready) begin
      vld_p0   <= prev_vld;
      data_p0  <= shifted;
      shift_p0 <= prev_shift;
      dir_p0   <= prev_dir;
      mode_p0  <= prev_mode;
      sign_p0  <= prev_sign;
      tag_p0   <= prev_tag;
    end
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered power-of-two step per stage,
// valid/ready on both sides, with a tag carried alongside each operation.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shift,
  input  logic                     in_direction,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
);
  localparam int SW = $clog2(WIDTH);

  // Index 0 is the input port; index k+1 is the register output of stage k.
  logic [SW:0]        vld;
  logic [SW:0]        dir;
  logic [SW:0]        sign;
  logic [WIDTH-1:0]   data_s  [SW+1];
  logic [SW-1:0]      shift_s [SW+1];
  logic [1:0]         mode_s  [SW+1];
  logic [TAG_W-1:0]   tag_s   [SW+1];
  logic [SW-1:0]      rdy_s;

  assign vld[0]     = in_valid;
  assign data_s[0]  = in_data;
  assign shift_s[0] = in_shift;
  assign dir[0]     = in_direction;
  assign mode_s[0]  = in_mode;
  assign sign[0]    = in_data[WIDTH-1];
  assign tag_s[0]   = in_tag;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic nxt_rdy;

    // Downstream ready is flattened over the later valids so the chain has
    // no self-referencing combinational net; it equals !vld_{k+1} || ready_{k+2}.
    if (k == SW - 1) begin : g_last
      assign nxt_rdy = out_ready;
    end else begin : g_mid
      assign nxt_rdy = out_ready || !(&vld[SW:k+2]);
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .STEP  (1 << k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .prev_vld   (vld[k]),
      .prev_data  (data_s[k]),
      .prev_shift (shift_s[k]),
      .prev_dir   (dir[k]),
      .prev_mode  (mode_s[k]),
      .prev_sign  (sign[k]),
      .prev_tag   (tag_s[k]),
      .next_ready (nxt_rdy),
      .ready      (rdy_s[k]),
      .vld_p0     (vld[k+1]),
      .data_p0    (data_s[k+1]),
      .shift_p0   (shift_s[k+1]),
      .dir_p0     (dir[k+1]),
      .mode_p0    (mode_s[k+1]),
      .sign_p0    (sign[k+1]),
      .tag_p0     (tag_s[k+1])
    );
  end

  assign in_ready  = rdy_s[0] && !rst;
  assign out_valid = vld[SW];
  assign out_data  = data_s[SW];
  assign out_tag   = tag_s[SW];
  assign out_zero  = vld[SW] && (data_s[SW] == '0);

  logic unused_tail;
  assign unused_tail = ^{shift_s[SW], dir[SW], mode_s[SW], sign[SW], rdy_s[SW-1:1]};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized bench for pipelined_barrel_shifter at WIDTH=8.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shift = '0;
  logic          in_direction = 1'b0;
  logic [1:0]    in_mode = 2'b00;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_shift     (in_shift),
    .in_direction (in_direction),
    .in_mode      (in_mode),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_zero     (out_zero)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-operation reference: the full shift in one step with SV operators.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s,
                                              input logic dir, input logic [1:0] mode);
    logic signed [W-1:0] sd;
    sd = d;
    if (mode == 2'b10) return dir ? ((d >> s) | (d << (W - s))) : ((d << s) | (d >> (W - s)));
    if (mode == 2'b01 && dir) return sd >>> s;
    return dir ? (d >> s) : (d << s);
  endfunction

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [TW-1:0] tag_log[$];
  int            cyc_log[$];

  // Scoreboard: accepted operations queue up, each output transfer must match the head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("unexpected_output", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_data", out_data, mon_e.d);
          chk("sb_tag", out_tag, mon_e.t);
          chk("sb_zero", out_zero, mon_e.d == 0);
        end
        tag_log.push_back(out_tag);
        cyc_log.push_back(cyc);
      end
      if (in_valid && in_ready)
        exp_q.push_back('{ref_shift(in_data, in_shift, in_direction, in_mode), in_tag});
    end
  end

  task automatic issue(input logic [W-1:0] d, input int s, input logic dir,
                       input logic [1:0] mode, input logic [TW-1:0] tag);
    int n;
    in_data = d; in_shift = SW'(s); in_direction = dir; in_mode = mode; in_tag = tag;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [W-1:0] d, input int s, input logic dir,
                        input logic [1:0] mode, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp, input string name);
    issue(d, s, dir, mode, tag);
    in_valid = 1'b0;
    @(negedge clk); chk({name, "_early1"}, out_valid, 0);
    @(negedge clk); chk({name, "_early2"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, exp);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_zero"}, out_zero, exp == 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  int  base;
  bit  rnd_done;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_zero", out_zero, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    single(8'hF0, 2, 1'b1, 2'b00, 4'h1, 8'h3C, "lsr2");
    single(8'hF0, 2, 1'b1, 2'b01, 4'h2, 8'hFC, "asr2");
    single(8'h96, 3, 1'b0, 2'b10, 4'h3, 8'hB4, "rol3");
    single(8'h96, 3, 1'b1, 2'b10, 4'h4, 8'hD2, "ror3");
    single(8'hF0, 4, 1'b0, 2'b00, 4'h5, 8'h00, "lsl4_zero");
    single(8'h01, 7, 1'b0, 2'b00, 4'h6, 8'h80, "lsl7");
    single(8'h80, 7, 1'b1, 2'b01, 4'h7, 8'hFF, "asr7");
    single(8'h96, 5, 1'b0, 2'b01, 4'h8, 8'hC0, "asl5");
    single(8'h96, 3, 1'b1, 2'b11, 4'h9, 8'h12, "rsvd_r3");
    single(8'h96, 3, 1'b1, 2'b00, 4'hA, 8'h12, "log_r3");
    for (int m = 0; m < 4; m++) begin
      single(8'hA5, 0, 1'b1, 2'(m), 4'(m), 8'hA5, "shift0_r");
      single(8'h5A, 0, 1'b0, 2'(m), 4'(m), 8'h5A, "shift0_l");
    end

    // Back-to-back stream, one result per cycle in order.
    base = tag_log.size();
    for (int i = 0; i < 6; i++)
      issue(W'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(i));
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stream_count", tag_log.size() - base, 6);
    for (int i = 0; i < 6; i++) chk("stream_tag", tag_log[base+i], i);
    for (int i = 1; i < 6; i++) chk("stream_gap", cyc_log[base+i] - cyc_log[base+i-1], 1);

    // Stall mid-stream: three held operations fill the pipe.
    base = tag_log.size();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(W'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(i));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    for (int i = 3; i < 6; i++)
      issue(W'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(i));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("stall_count", tag_log.size() - base, 6);
    for (int i = 0; i < 6; i++) chk("stall_tag", tag_log[base+i], i);

    // Random operations under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++)
          issue(W'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'(i));
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("random_drained", exp_q.size(), 0);

    // Reset with two operations in flight.
    base = tag_log.size();
    issue(8'h3C, 1, 1'b0, 2'b00, 4'hA);
    issue(8'hC3, 2, 1'b1, 2'b01, 4'hB);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready_after", in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("flushed_out_valid", out_valid, 0);
    end
    @(posedge clk); #1;
    single(8'hF0, 2, 1'b1, 2'b00, 4'hC, 8'h3C, "post_rst");
    chk("no_ghost_count", tag_log.size() - base, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
